// File: rtl/fifo_rr_scheduler.sv
// Purpose: round-robin scheduler that moves words from 4 input FIFOs to 4 output FIFOs in bursts of up to BURST words.
// Latency: an eligible input seen in IDLE at cycle N is popped at N+1, and its word is pushed at N+2.
// Backpressure: an empty source or an almost-full destination stops pops in the same cycle; the in-flight push still completes.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   enable              scheduling permitted
//   empty_in[3:0]       input FIFO empty flags
//   head_dest[7:0]      destination of each input head word, bits [2i+1:2i] = input i
//   afull_in[3:0]       output FIFO almost-full flags
//   pop_out[3:0]        input FIFO pop strobe (combinational, at most one bit high)
//   push_out[3:0]       output FIFO push strobe (registered, one-hot or zero)
//   sel_out, dest_out   datapath source select / destination of the pushed word
//   busy_out            high in GRANT or while a push is pending
module fifo_rr_scheduler #(
    parameter int BURST = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] empty_in,
    input  logic [7:0] head_dest,
    input  logic [3:0] afull_in,
    output logic [3:0] pop_out,
    output logic [3:0] push_out,
    output logic [1:0] sel_out,
    output logic [1:0] dest_out,
    output logic       busy_out
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Source and destination captured at the pop, replayed on the push one cycle later.
    typedef struct packed {
        logic [1:0] sel;
        logic [1:0] dest;
    } push_meta_t;

    state_t     state;
    logic [1:0] owner;
    logic [1:0] ptr;
    logic [3:0] bcnt;
    logic [3:0] push_q;
    push_meta_t meta_q;

    logic [3:0] elig;
    logic [1:0] owner_dest;
    logic       owner_ok;
    logic       do_pop;
    logic       last_pop;
    logic       burst_end;
    logic [2:0] idle_pick;
    logic [2:0] end_pick;

    // Returns {found, index} for the first set bit of el scanning base, base+1, ... modulo 4.
    // Scanning from the far end and overwriting leaves the nearest hit.
    function automatic logic [2:0] rr_pick(input logic [3:0] el, input logic [1:0] base);
        logic [2:0] r;
        logic [1:0] c;
        r = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            c = base + 2'(k);
            if (el[c]) begin
                r = {1'b1, c};
            end
        end
        return r;
    endfunction

    always_comb begin
        elig = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            elig[i] = !empty_in[i] && !afull_in[head_dest[2*i +: 2]];
        end
    end

    assign owner_dest = head_dest[{owner, 1'b0} +: 2];
    assign owner_ok   = enable && elig[owner];
    assign do_pop     = !reset && (state == GRANT) && owner_ok;
    assign last_pop   = do_pop && ((bcnt + 4'd1) == 4'(BURST));
    assign burst_end  = (state == GRANT) && (!owner_ok || last_pop);
    assign idle_pick  = rr_pick(elig, ptr);
    // Re-arbitration after a burst starts one past the old owner, so it is considered last.
    assign end_pick   = rr_pick(elig, owner + 2'd1);

    // Outputs are forced low while reset is asserted, so a push registered just
    // before reset never reaches the output FIFOs.
    assign pop_out  = do_pop ? (4'b0001 << owner) : 4'b0000;
    assign push_out = reset ? 4'b0000 : push_q;
    assign sel_out  = reset ? 2'b00 : meta_q.sel;
    assign dest_out = reset ? 2'b00 : meta_q.dest;
    assign busy_out = !reset && ((state == GRANT) || (push_q != 4'b0000));

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            owner  <= 2'd0;
            ptr    <= 2'd0;
            bcnt   <= 4'd0;
            push_q <= 4'b0000;
            meta_q <= '0;
        end else begin
            push_q <= do_pop ? (4'b0001 << owner_dest) : 4'b0000;
            if (do_pop) begin
                meta_q <= '{sel: owner, dest: owner_dest};
            end

            case (state)
                IDLE: begin
                    if (enable && idle_pick[2]) begin
                        state <= GRANT;
                        owner <= idle_pick[1:0];
                        bcnt  <= 4'd0;
                    end
                end
                GRANT: begin
                    if (!enable) begin
                        state <= IDLE;
                        ptr   <= owner + 2'd1;
                        bcnt  <= 4'd0;
                    end else if (burst_end) begin
                        ptr  <= owner + 2'd1;
                        bcnt <= 4'd0;
                        if (end_pick[2]) begin
                            owner <= end_pick[1:0];
                        end else begin
                            state <= IDLE;
                        end
                    end else if (do_pop) begin
                        bcnt <= bcnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
